// File: rtl/fp16_add_wrapper.sv
// fp16_add_wrapper: pipelined binary16 adder (RNE), fixed LAT-cycle latency, one op per cycle.
// Define FP16_ADD_FTZ_EN to flush subnormal inputs and subnormal results to signed zero.
module fp16_add_wrapper #(
  parameter int DW  = 16,
  parameter int LAT = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          valid_out
);
  typedef struct packed {
    logic        sign;   // sign of the larger-magnitude operand
    logic        zsign;  // sign of an exact-zero sum
    logic        spec;
    logic [15:0] sval;
  } meta_t;

  logic [LAT:1] vld_pipe;
  always_ff @(posedge clk)
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[LAT-1:1], valid_in};
  assign valid_out = vld_pipe[LAT];

  // S1: input register
  logic [15:0] s1_a, s1_b;
  always_ff @(posedge clk) begin
    s1_a <= a;
    s1_b <= b;
  end

  // S2: unpack, compare/swap, special detect
  logic [4:0]  ea, eb;
  logic [10:0] ma, mb;
  logic        a_nan, b_nan, a_inf, b_inf, a_big;
  meta_t       m2_nxt;
  always_comb begin
    ea = (s1_a[14:10] == 5'd0) ? 5'd1 : s1_a[14:10];
    eb = (s1_b[14:10] == 5'd0) ? 5'd1 : s1_b[14:10];
    ma = {s1_a[14:10] != 5'd0, s1_a[9:0]};
    mb = {s1_b[14:10] != 5'd0, s1_b[9:0]};
`ifdef FP16_ADD_FTZ_EN
    if (s1_a[14:10] == 5'd0) ma = '0;
    if (s1_b[14:10] == 5'd0) mb = '0;
`endif
    a_nan = (&s1_a[14:10]) & (|s1_a[9:0]);
    b_nan = (&s1_b[14:10]) & (|s1_b[9:0]);
    a_inf = (&s1_a[14:10]) & ~(|s1_a[9:0]);
    b_inf = (&s1_b[14:10]) & ~(|s1_b[9:0]);
    a_big = {ea, ma} >= {eb, mb};
    m2_nxt.sign  = a_big ? s1_a[15] : s1_b[15];
    m2_nxt.zsign = s1_a[15] & s1_b[15];
    m2_nxt.spec  = a_nan | b_nan | a_inf | b_inf;
    if (a_nan | b_nan | (a_inf & b_inf & (s1_a[15] ^ s1_b[15]))) m2_nxt.sval = 16'h7E00;
    else if (a_inf)                                               m2_nxt.sval = s1_a;
    else                                                          m2_nxt.sval = s1_b;
  end

  meta_t       s2_m;
  logic [6:0]  s2_exp;
  logic [10:0] s2_bman, s2_sman;
  logic [4:0]  s2_diff;
  logic        s2_sub;
  always_ff @(posedge clk) begin
    s2_m    <= m2_nxt;
    s2_exp  <= {2'b00, a_big ? ea : eb};
    s2_bman <= a_big ? ma : mb;
    s2_sman <= a_big ? mb : ma;
    s2_diff <= a_big ? ea - eb : eb - ea;
    s2_sub  <= s1_a[15] ^ s1_b[15];
  end

  // S3: align; aligned word is {11 significand bits, guard, round, sticky}
  logic [3:0]  ash;
  logic [25:0] wide;
  always_comb begin
    ash  = (s2_diff > 5'd13) ? 4'd13 : s2_diff[3:0];
    wide = {s2_sman, 15'd0} >> ash;
  end

  meta_t       s3_m;
  logic [6:0]  s3_exp;
  logic [13:0] s3_big, s3_small;
  logic        s3_sub;
  always_ff @(posedge clk) begin
    s3_m     <= s2_m;
    s3_exp   <= s2_exp;
    s3_sub   <= s2_sub;
    s3_big   <= {s2_bman, 3'b000};
    s3_small <= {wide[25:13], |wide[12:0]};
  end

  // S4: add/sub (larger magnitude first, so never negative)
  meta_t       s4_m;
  logic [6:0]  s4_exp;
  logic [14:0] s4_sum;
  always_ff @(posedge clk) begin
    s4_m   <= s3_m;
    s4_exp <= s3_exp;
    s4_sum <= s3_sub ? {1'b0, s3_big} - {1'b0, s3_small} : {1'b0, s3_big} + {1'b0, s3_small};
  end

  // S5: leading-zero count of the non-carry bits
  logic [3:0] lz;
  always_comb begin
    lz = 4'd14;
    for (int i = 0; i < 14; i++)
      if (s4_sum[i]) lz = 4'(13 - i);
  end

  meta_t       s5_m;
  logic [6:0]  s5_exp;
  logic [14:0] s5_sum;
  logic [3:0]  s5_lz;
  always_ff @(posedge clk) begin
    s5_m   <= s4_m;
    s5_exp <= s4_exp;
    s5_sum <= s4_sum;
    s5_lz  <= lz;
  end

  // S6: normalize; left shift stops at exponent 1 so results land as subnormals
  logic [6:0]  emax_sh, nsh, nexp;
  logic [13:0] nrm;
  always_comb begin
    emax_sh = s5_exp - 7'd1;
    nsh     = ({3'd0, s5_lz} < emax_sh) ? {3'd0, s5_lz} : emax_sh;
    if (s5_sum[14]) begin
      nrm  = {s5_sum[14:2], s5_sum[1] | s5_sum[0]};
      nexp = s5_exp + 7'd1;
    end else begin
      nrm  = s5_sum[13:0] << nsh;
      nexp = s5_exp - nsh;
    end
  end

  meta_t       s6_m;
  logic [6:0]  s6_exp;
  logic [13:0] s6_nrm;
  always_ff @(posedge clk) begin
    s6_m   <= s5_m;
    s6_exp <= nexp;
    s6_nrm <= nrm;
  end

  // S7: round to nearest even; a carry out renormalizes
  logic [11:0] rnd;
  always_comb
    rnd = {1'b0, s6_nrm[13:3]} + 12'(s6_nrm[2] & (s6_nrm[3] | s6_nrm[1] | s6_nrm[0]));

  meta_t       s7_m;
  logic [6:0]  s7_exp;
  logic [10:0] s7_man;
  always_ff @(posedge clk) begin
    s7_m   <= s6_m;
    s7_exp <= rnd[11] ? s6_exp + 7'd1 : s6_exp;
    s7_man <= rnd[11] ? rnd[11:1] : rnd[10:0];
  end

  // S8: pack with special override, then output delay line
  logic [15:0] pack_nxt;
  always_comb begin
    if (s7_m.spec)             pack_nxt = s7_m.sval;
    else if (s7_man == 11'd0)  pack_nxt = {s7_m.zsign, 15'd0};
    else if (s7_exp >= 7'd31)  pack_nxt = {s7_m.sign, 15'h7C00};
    else if (!s7_man[10])
`ifdef FP16_ADD_FTZ_EN
      pack_nxt = {s7_m.sign, 15'd0};
`else
      pack_nxt = {s7_m.sign, 5'd0, s7_man[9:0]};
`endif
    else                       pack_nxt = {s7_m.sign, s7_exp[4:0], s7_man[9:0]};
  end

  logic [LAT-8:0][15:0] dly;
  always_ff @(posedge clk)
    if (rst) dly <= '0;
    else begin
      dly[0] <= pack_nxt;
      for (int i = 1; i <= LAT - 8; i++) dly[i] <= dly[i-1];
    end
  assign result = dly[LAT-8];
endmodule

// File: tb/tb_fp16_add_wrapper.sv
// Self-checking bench for fp16_add_wrapper: directed vectors, random streaming against a
// real-arithmetic reference model, and reset behaviour.
module tb_fp16_add_wrapper;
  localparam int LAT = 11;
  localparam int NSTREAM = 1000;

  logic        clk = 1'b0, rst = 1'b1, valid_in = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [15:0] result;
  logic        valid_out;
  int          n_cmp = 0, n_err = 0;

  fp16_add_wrapper #(.DW(16), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .a(a), .b(b),
    .result(result), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: exact real sum, then RNE to binary16 ----------------
  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) repeat (e) r = r * 2.0;
    else        repeat (-e) r = r / 2.0;
    return r;
  endfunction

  function automatic logic is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
  endfunction

  function automatic logic is_inf(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
  endfunction

  function automatic real to_real(input logic [15:0] x);
    real v;
    if (x[14:10] == 5'd0) v = real'(int'(x[9:0])) * pow2(-24);
    else                  v = real'(1024 + int'(x[9:0])) * pow2(int'(x[14:10]) - 25);
    return x[15] ? -v : v;
  endfunction

  function automatic logic [15:0] ref_add(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] p, q;
    real s, mag, qt, rem;
    int e, fl;
    logic sg;
    if (is_nan(x) || is_nan(y)) return 16'h7E00;
    if (is_inf(x) && is_inf(y) && (x[15] != y[15])) return 16'h7E00;
    if (is_inf(x)) return x;
    if (is_inf(y)) return y;
    p = x; q = y;
`ifdef FP16_ADD_FTZ_EN
    if (p[14:10] == 5'd0) p = {p[15], 15'd0};
    if (q[14:10] == 5'd0) q = {q[15], 15'd0};
`endif
    s = to_real(p) + to_real(q);
    if (s == 0.0) return {p[15] & q[15], 15'd0};
    sg  = (s < 0.0);
    mag = sg ? -s : s;
    e = -14;
    while (mag >= pow2(e + 1)) e++;
    qt  = mag / pow2(e - 10);
    fl  = $rtoi(qt);
    rem = qt - real'(fl);
    if (rem > 0.5 || (rem == 0.5 && (fl % 2) == 1)) fl++;
    if (fl == 2048) begin e++; fl = 1024; end
    if (fl < 1024) begin
`ifdef FP16_ADD_FTZ_EN
      return {sg, 15'd0};
`else
      return {sg, 5'd0, 10'(fl)};
`endif
    end
    if (e > 15) return {sg, 15'h7C00};
    return {sg, 5'(e + 15), 10'(fl - 1024)};
  endfunction

  // Issue one op into an idle pipe; report the result and cycles until valid_out.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                        output logic [15:0] res, output int lat);
    @(negedge clk); a = x; b = y; valid_in = 1'b1;
    @(negedge clk); valid_in = 1'b0; lat = 1;
    while (!valid_out && lat < 4 * LAT) begin @(negedge clk); lat++; end
    res = result;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int seen = 0;
    rst = 1'b1; valid_in = 1'b1; a = 16'h3C00; b = 16'h3C00;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
    n_cmp++;
    if (result !== 16'h0000) begin n_err++; $display("FAIL reset_result: got %h want 0000", result); end
    rst = 1'b0; valid_in = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin @(negedge clk); if (valid_out === 1'b1) seen++; end
    n_cmp++;
    if (seen != 0) begin n_err++; $display("FAIL reset_ignored_valid: got %0d pulses want 0", seen); end
  endtask

  task automatic test_basic();
    logic [47:0] vec [5] = '{48'h3C00_3C00_4000, 48'h3C00_BC00_0000, 48'h3C00_1000_3C00,
                             48'h3C01_1000_3C02, 48'h4200_C000_3C00};
    logic [15:0] res;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(vec[i][47:32], vec[i][31:16], res, lat);
      n_cmp++;
      if (lat != LAT) begin n_err++; $display("FAIL basic[%0d] latency: got %0d want %0d", i, lat, LAT); end
      n_cmp++;
      if (res !== vec[i][15:0]) begin
        n_err++; $display("FAIL basic[%0d] %h+%h: got %h want %h", i, vec[i][47:32], vec[i][31:16], res, vec[i][15:0]);
      end
    end
  endtask

  task automatic test_specials();
    logic [47:0] vec [5] = '{48'h7BFF_7BFF_7C00, 48'h7C00_FC00_7E00, 48'h7E01_3C00_7E00,
                             48'h8000_8000_8000, 48'h0000_8000_0000};
    logic [15:0] res;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(vec[i][47:32], vec[i][31:16], res, lat);
      n_cmp++;
      if (res !== vec[i][15:0] || lat != LAT) begin
        n_err++; $display("FAIL special[%0d] %h+%h: got %h lat %0d want %h lat %0d",
                          i, vec[i][47:32], vec[i][31:16], res, lat, vec[i][15:0], LAT);
      end
    end
  endtask

  task automatic test_subnormal();
`ifdef FP16_ADD_FTZ_EN
    logic [47:0] vec [3] = '{48'h0001_0001_0000, 48'h03FF_0001_0000, 48'h0400_8001_0400};
`else
    logic [47:0] vec [3] = '{48'h0001_0001_0002, 48'h03FF_0001_0400, 48'h0400_8001_03FF};
`endif
    logic [15:0] res;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(vec[i][47:32], vec[i][31:16], res, lat);
      n_cmp++;
      if (res !== vec[i][15:0] || lat != LAT) begin
        n_err++; $display("FAIL subnormal[%0d] %h+%h: got %h lat %0d want %h lat %0d",
                          i, vec[i][47:32], vec[i][31:16], res, lat, vec[i][15:0], LAT);
      end
    end
  endtask

  task automatic test_stream();
    logic        hv [NSTREAM];
    logic [15:0] hr [NSTREAM];
    logic [15:0] x, y;
    int          r;
    for (int t = 0; t < NSTREAM + LAT; t++) begin
      @(negedge clk);
      if (t >= LAT) begin
        n_cmp++;
        if (valid_out !== hv[t-LAT]) begin
          n_err++; $display("FAIL stream_valid[%0d]: got %b want %b", t - LAT, valid_out, hv[t-LAT]);
        end else if (hv[t-LAT]) begin
          n_cmp++;
          if (result !== hr[t-LAT]) begin
            n_err++; $display("FAIL stream_result[%0d]: got %h want %h", t - LAT, result, hr[t-LAT]);
          end
        end
      end else begin
        n_cmp++;
        if (valid_out !== 1'b0) begin n_err++; $display("FAIL stream_idle[%0d]: got %b want 0", t, valid_out); end
      end
      if (t < NSTREAM) begin
        x = 16'($urandom);
        r = $urandom_range(0, 9);
        if (r < 4)       y = 16'($urandom);
        else if (r < 7)  y = {~x[15], x[14:10], x[9:0] ^ 10'($urandom_range(0, 15))};
        else if (r == 7) begin
          x = {1'($urandom), 5'd0, 10'($urandom)};
          y = {1'($urandom), 5'($urandom_range(0, 2)), 10'($urandom)};
        end else if (r == 8) begin
          x = {1'($urandom), 5'd30, 10'($urandom)};
          y = {x[15], 5'($urandom_range(28, 30)), 10'($urandom)};
        end else         y = {1'($urandom), 5'($urandom_range(0, 30)), 10'($urandom)};
        hv[t] = ($urandom_range(0, 3) != 0);
        hr[t] = ref_add(x, y);
        a = x; b = y; valid_in = hv[t];
      end else valid_in = 1'b0;
    end
  endtask

  task automatic test_reset_flight();
    logic [15:0] res;
    int lat;
    int seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); a = 16'h3C00 + 16'(i); b = 16'h4000; valid_in = 1'b1;
    end
    @(negedge clk); rst = 1'b1; valid_in = 1'b1; a = 16'h3C00; b = 16'h3C00;
    @(negedge clk); rst = 1'b0; valid_in = 1'b0;
    n_cmp++;
    if (result !== 16'h0000) begin n_err++; $display("FAIL flight_reset_result: got %h want 0000", result); end
    n_cmp++;
    if (valid_out !== 1'b0) begin n_err++; $display("FAIL flight_reset_valid: got %b want 0", valid_out); end
    for (int i = 0; i < 2 * LAT; i++) begin @(negedge clk); if (valid_out === 1'b1) seen++; end
    n_cmp++;
    if (seen != 0) begin n_err++; $display("FAIL flight_discard: got %0d pulses want 0", seen); end
    run_op(16'h4200, 16'hC000, res, lat);
    n_cmp++;
    if (lat != LAT) begin n_err++; $display("FAIL flight_post_latency: got %0d want %0d", lat, LAT); end
    n_cmp++;
    if (res !== 16'h3C00) begin n_err++; $display("FAIL flight_post_result: got %h want 3C00", res); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_specials();
    test_subnormal();
    test_stream();
    test_reset_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fp16_add_wrapper.md
# fp16_add_wrapper

Pipelined IEEE 754 binary16 (FP16) adder with a valid-tag pipeline. It computes `result = a + b` with a fixed latency, accepts a new operand pair every cycle, and is the per-lane adder that the SSM state-update datapath instantiates once per (h,p,n) element. It has no back-pressure: downstream logic must absorb `valid_out` whenever it pulses.

## Interface
Parameters:
- `DW`, 16: operand and result width. Only 16 is supported.
- `LAT`, 11: total latency in cycles from `valid_in` to `valid_out`. Legal range is 8..16. Stages beyond the 8 arithmetic stages are output delay registers.

Ports:
- `clk`, input, 1: clock. All logic is rising-edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `valid_in`, input, 1: operand pair on `a`/`b` is valid this cycle.
- `a`, input, 16: FP16 operand.
- `b`, input, 16: FP16 operand.
- `result`, output, 16: FP16 sum, registered.
- `valid_out`, output, 1: `result` is valid this cycle. Registered.

## Operation
- Format: 1 sign bit, 5 exponent bits (bias 15), 10 fraction bits.
- Rounding is round-to-nearest, ties-to-even. Guard, round and sticky bits are kept through alignment.
- Subnormals get full gradual underflow by default (see Configuration).
- Special cases, in order of priority:
  - Either operand NaN → `16'h7E00` (canonical quiet NaN; the payload is not propagated).
  - +Inf + −Inf → `16'h7E00`.
  - Inf + finite, or same-sign Infs → that Inf.
  - Finite overflow after rounding → ±Inf (`7C00`/`FC00`).
  - Exact zero result from operands of opposite sign → +0.
  - (−0) + (−0) → −0. (+0) + (−0) → +0.
- Arithmetic flow:
  1. Unpack: implicit 1 for normals, exponent 1 for subnormals.
  2. Swap operands so the larger magnitude is first.
  3. Right-shift the smaller significand by the exponent difference, clamped at 13 or more, with bits shifted out ORed into sticky.
  4. Add or subtract the significands.
  5. Count leading zeros.
  6. Normalize: the left shift is limited so the exponent does not go below 1; a carry-out shifts right by 1.
  7. Round. A rounding carry can renormalize.
  8. Pack, with the special-case override.
- Nominal stage map:
  - S1: input register and unpack.
  - S2: compare/swap and special detect.
  - S3: align.
  - S4: add/sub.
  - S5: LZC.
  - S6: normalize.
  - S7: round.
  - S8: pack.
  - S9..S`LAT`: delay.
- The data path advances every cycle regardless of `valid_in`. Only the valid tag marks meaningful outputs.
- `result` is don't-care while `valid_out` = 0.
- The block is combinationally pure per operand pair: no state is carried between operations.

## Timing
- Reset (`rst` = 1 at a rising edge):
  - Clears every valid-pipeline bit.
  - Sets `result` to `16'h0000` and `valid_out` to 0.
  - Data registers other than `result` need not be reset.
- Latency: `valid_in` = 1 with `a`/`b` sampled at edge k gives `valid_out` = 1 and the matching `result` during the cycle after edge k+`LAT`−1. That is exactly `LAT` (11) cycles, fixed and independent of operand values.
- Throughput is 1 operation per cycle. N back-to-back valid inputs produce N back-to-back valid outputs in the same order.
- Bubbles in `valid_in` appear as bubbles in `valid_out` after the same delay.
- Reset mid-operation: all in-flight operations are discarded and none emerge. After `rst` falls, `valid_out` stays 0 until `LAT` cycles after the next accepted `valid_in`.
- `valid_in` asserted in the same cycle as `rst` = 1 is ignored.

## Configuration
- `FP16_ADD_FTZ_EN` defined:
  - Subnormal inputs are treated as zero of the same sign.
  - Any result that would be subnormal after rounding is flushed to zero of the computed sign.
  - Latency is unchanged.
- `FP16_ADD_FTZ_EN` undefined: full IEEE subnormal support (inputs and outputs), per Operation.

## Test plan
- Basic/rounding: sweep these pairs, each 11 cycles to output:
  - `3C00`+`3C00` → `4000`.
  - `3C00`+`BC00` → `0000`.
  - `3C00`+`1000` → `3C00` (tie to even).
  - `3C01`+`1000` → `3C02`.
  - `4200`+`C000` → `3C00`.
- Specials:
  - `7BFF`+`7BFF` → `7C00`.
  - `7C00`+`FC00` → `7E00`.
  - `7E01`+`3C00` → `7E00`.
  - `8000`+`8000` → `8000`.
  - `0000`+`8000` → `0000`.
- Subnormals, FTZ off:
  - `0001`+`0001` → `0002`.
  - `03FF`+`0001` → `0400`.
  - `0400`+`8001` → `03FF`.
- Same subnormal vectors, FTZ on: `0001`+`0001` → `0000`, `03FF`+`0001` → `0000`, `0400`+`8001` → `0400`.
- Streaming: 1000 random pairs on consecutive cycles with random `valid_in` bubbles → `valid_out` pattern equals `valid_in` delayed 11 cycles, and every result bit-matches the reference model.
- Reset: assert `rst` for 1 cycle while 5 operations are in flight → no `valid_out` pulse for those 5. `result` = `0000` and `valid_out` = 0 after the reset edge. A new input after reset appears exactly 11 cycles later.
